// File: rtl/instr_prefetch_queue_pkg.sv
// Shared instruction-format constants for the prefetch queue, control unit and register file.
// Field offsets assume the default 16-bit word with a 7-bit control field and 3-bit specifiers.
package instr_prefetch_queue_pkg;

  localparam int unsigned IQ_WIDTH = 16;
  localparam int unsigned IQ_CTRLW = 7;
  localparam int unsigned IQ_REGW  = 3;

  localparam int unsigned CTRL_LSB = 0;
  localparam int unsigned REGB_LSB = IQ_CTRLW;
  localparam int unsigned REGA_LSB = IQ_CTRLW + IQ_REGW;
  localparam int unsigned REGD_LSB = IQ_CTRLW + 2 * IQ_REGW;

  // Source selected for the next IR value.
  typedef enum logic [1:0] {
    IrHold,
    IrFromFifo,
    IrFromInput,
    IrBubble
  } ir_sel_e;

  function automatic bit fields_fit(int unsigned width, int unsigned ctrlw, int unsigned regw);
    return (ctrlw + 3 * regw) == width;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding prefetched instruction words ahead of the IR.
// Occupancy count is the only full/empty indicator; pointers wrap modulo DEPTH.
module instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;

  always_ff @(posedge CLK) begin
    if (Reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (push && !pop) begin
        count <= count + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PtrW + 1)'(1);
      end
    end
  end

  // Storage needs no reset; the caller never pushes during reset or clear.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch FIFO feeding the current-instruction register, with flush and optional empty bypass.
// Decoded fields are plain slices of the IR register.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH  = IQ_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CTRLW  = IQ_CTRLW,
  parameter int unsigned REGW   = IQ_REGW,
  parameter int unsigned BYPASS = 1
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       input_IQ_Instru,
  input  logic                   input_IQ_valid,
  output logic                   Output_IQ_ready,
  input  logic                   input_IQ_advance,
  input  logic                   input_IQ_flush,
  output logic                   Output_IQ_valid,
  output logic [$clog2(DEPTH):0] Output_IQ_count,
  output logic [CTRLW-1:0]       Output_IR_Control,
  output logic [REGW-1:0]        Output_IR_RegB,
  output logic [REGW-1:0]        Output_IR_RegA,
  output logic [REGW-1:0]        Output_IR_RegD,
  output logic [WIDTH-1:0]       Output_IR_Imm
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  if (!fields_fit(WIDTH, CTRLW, REGW)) begin : g_width_check
    $error("instr_prefetch_queue: CTRLW + 3*REGW must equal WIDTH");
  end

  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] ir;
  logic             ir_valid;
  logic             empty;
  logic             ready;
  logic             push;
  logic             pop;
  ir_sel_e          sel;

  assign empty = (count == '0);
  assign ready = (count != CntW'(DEPTH));

  always_comb begin
    sel = IrHold;
    if (input_IQ_advance) begin
      if (!empty) begin
        sel = IrFromFifo;
      end else if (input_IQ_valid && (BYPASS != 0)) begin
        sel = IrFromInput;
      end else if (!input_IQ_valid) begin
        sel = IrBubble;
      end
    end
  end

  // A bypassed word goes straight to the IR and never occupies a FIFO slot.
  assign push = input_IQ_valid && ready && !Reset && !input_IQ_flush && (sel != IrFromInput);
  assign pop  = (sel == IrFromFifo) && !Reset && !input_IQ_flush;

  instr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .clear (input_IQ_flush),
    .push  (push),
    .pop   (pop),
    .wdata (input_IQ_Instru),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (input_IQ_flush) begin
      ir_valid <= 1'b0;
    end else begin
      unique case (sel)
        IrFromFifo: begin
          ir       <= head;
          ir_valid <= 1'b1;
        end
        IrFromInput: begin
          ir       <= input_IQ_Instru;
          ir_valid <= 1'b1;
        end
        IrBubble: ir_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign Output_IQ_ready   = ready;
  assign Output_IQ_valid   = ir_valid;
  assign Output_IQ_count   = count;
  assign Output_IR_Control = ir[CTRLW-1:0];
  assign Output_IR_RegB    = ir[CTRLW+REGW-1:CTRLW];
  assign Output_IR_RegA    = ir[CTRLW+2*REGW-1:CTRLW+REGW];
  assign Output_IR_RegD    = ir[WIDTH-1:WIDTH-REGW];
  assign Output_IR_Imm     = ir;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Drives a BYPASS=0 and a BYPASS=1 queue with identical stimulus and checks both every cycle
// against a queue-based reference model, plus literal expectations for the directed scenarios.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] din;
  logic        vin;
  logic        adv;
  logic        flush;

  logic        ready [2];
  logic        valid [2];
  logic [2:0]  count [2];
  logic [6:0]  ctrl  [2];
  logic [2:0]  rega  [2];
  logic [2:0]  regb  [2];
  logic [2:0]  regd  [2];
  logic [15:0] imm   [2];

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 is the BYPASS=0 instance, index 1 the BYPASS=1 instance.
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [15:0] m_ir  [2];
  logic        m_vld [2];

  always #5 CLK = ~CLK;

  for (genvar b = 0; b < 2; b++) begin : g_dut
    instr_prefetch_queue #(
      .WIDTH  (16),
      .DEPTH  (DEPTH),
      .CTRLW  (7),
      .REGW   (3),
      .BYPASS (b)
    ) u_dut (
      .CLK               (CLK),
      .Reset             (Reset),
      .input_IQ_Instru   (din),
      .input_IQ_valid    (vin),
      .Output_IQ_ready   (ready[b]),
      .input_IQ_advance  (adv),
      .input_IQ_flush    (flush),
      .Output_IQ_valid   (valid[b]),
      .Output_IQ_count   (count[b]),
      .Output_IR_Control (ctrl[b]),
      .Output_IR_RegB    (regb[b]),
      .Output_IR_RegA    (rega[b]),
      .Output_IR_RegD    (regd[b]),
      .Output_IR_Imm     (imm[b])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int b);
    logic [15:0] q[$];
    logic [15:0] ir;
    logic        v;
    bit          can_push;
    if (b == 1) q = mq1;
    else        q = mq0;
    ir = m_ir[b];
    v  = m_vld[b];
    can_push = (q.size() < DEPTH);
    if (Reset) begin
      q.delete();
      ir = '0;
      v  = 1'b0;
    end else if (flush) begin
      q.delete();
      v = 1'b0;
    end else if (adv && q.size() > 0) begin
      ir = q.pop_front();
      v  = 1'b1;
      if (vin && can_push) q.push_back(din);
    end else if (adv && vin && b == 1) begin
      ir = din;
      v  = 1'b1;
    end else begin
      if (adv && !vin) v = 1'b0;
      if (vin && can_push) q.push_back(din);
    end
    if (b == 1) mq1 = q;
    else        mq0 = q;
    m_ir[b]  = ir;
    m_vld[b] = v;
  endtask

  task automatic compare_all();
    for (int b = 0; b < 2; b++) begin
      int sz;
      string s;
      sz = (b == 1) ? mq1.size() : mq0.size();
      s  = (b == 1) ? "byp1" : "byp0";
      chk({s, ".count"}, 32'(count[b]), 32'(sz));
      chk({s, ".ready"}, 32'(ready[b]), 32'(sz != DEPTH));
      chk({s, ".valid"}, 32'(valid[b]), 32'(m_vld[b]));
      chk({s, ".imm"},   32'(imm[b]),   32'(m_ir[b]));
      chk({s, ".fields"}, {13'd0, ctrl[b], rega[b], regb[b], regd[b]},
          {13'd0, m_ir[b][6:0], m_ir[b][12:10], m_ir[b][9:7], m_ir[b][15:13]});
    end
  endtask

  // Apply the current inputs for one clock edge, then check both instances.
  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic a,
                       input logic f);
    Reset = r; vin = v; din = d; adv = a; flush = f;
    step();
    Reset = 1'b0; vin = 1'b0; adv = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int b = 0; b < 2; b++) begin
      chk({tag, ".ctrl"},  32'(ctrl[b]),  32'd0);
      chk({tag, ".regs"},  {23'd0, rega[b], regb[b], regd[b]}, 32'd0);
      chk({tag, ".imm"},   32'(imm[b]),   32'h0000);
      chk({tag, ".valid"}, 32'(valid[b]), 32'd0);
      chk({tag, ".count"}, 32'(count[b]), 32'd0);
      chk({tag, ".ready"}, 32'(ready[b]), 32'd1);
    end
  endtask

  initial begin
    Reset = 1'b0; vin = 1'b0; din = '0; adv = 1'b0; flush = 1'b0;
    m_ir[0] = '0; m_ir[1] = '0; m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    @(negedge CLK);

    // 1: reset with every input high
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    check_reset_state("t1");

    // 2: push then advance
    drive(1'b0, 1'b1, 16'h1A2B, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t2.ctrl",  32'(ctrl[1]),  32'b0101011);
    chk("t2.rega",  32'(rega[1]),  32'b110);
    chk("t2.regb",  32'(regb[1]),  32'b100);
    chk("t2.regd",  32'(regd[1]),  32'b000);
    chk("t2.imm",   32'(imm[1]),   32'h1A2B);
    chk("t2.valid", 32'(valid[1]), 32'd1);
    chk("t2.count", 32'(count[1]), 32'd0);

    // 3: one push, then advance held low
    drive(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("t3.imm",   32'(imm[1]),   32'h1A2B);
    chk("t3.count", 32'(count[1]), 32'd1);

    // 4: drain, fill to full, overflow push, then drain past empty
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    chk("t4.count_full", 32'(count[1]), 32'd4);
    chk("t4.ready_full", 32'(ready[1]), 32'd0);
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    chk("t4.count_ovf", 32'(count[1]), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t4.ir_seq", 32'(imm[1]), 32'(i));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t4.bubble_valid", 32'(valid[1]), 32'd0);
    chk("t4.bubble_imm",   32'(imm[1]),   32'h0004);

    // 5: empty queue, push+advance
    drive(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("t5.byp1_imm",   32'(imm[1]),   32'hBEEF);
    chk("t5.byp1_count", 32'(count[1]), 32'd0);
    chk("t5.byp1_valid", 32'(valid[1]), 32'd1);
    chk("t5.byp0_imm",   32'(imm[0]),   32'h0004);
    chk("t5.byp0_count", 32'(count[0]), 32'd1);

    // 6: flush with concurrent push and advance
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    chk("t6.count_pre", 32'(count[1]), 32'd3);
    drive(1'b0, 1'b1, 16'h3333, 1'b1, 1'b1);
    chk("t6.count", 32'(count[1]), 32'd0);
    chk("t6.valid", 32'(valid[1]), 32'd0);
    chk("t6.imm",   32'(imm[1]),   32'hBEEF);
    chk("t6.imm0",  32'(imm[0]),   32'h0004);
    drive(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0);
    chk("t6.after_imm", 32'(imm[1]), 32'h2222);
    drive(1'b0, 1'b1, 16'h4444, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    check_reset_state("t6.reset");

    // Randomised traffic, checked every cycle by compare_all
    for (int n = 0; n < 600; n++) begin
      Reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 24) == 0);
      vin   = ($urandom_range(0, 99) < 60);
      adv   = ($urandom_range(0, 99) < 45);
      din   = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
